bridge_ahb_arbiter: RTL and testbench



---
 rtl/bridge_ahb_arbiter.sv | 145 ++++++++++++++
 tb/tb_bridge_ahb_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bridge_ahb_arbiter.sv
// Round-robin AHB arbiter for the AHB-to-APB bridge slave port; hands over only at burst boundaries.
// Optional locked-transfer support is compiled in when ARB_LOCK_EN is defined.
module bridge_ahb_arbiter #(
  parameter int unsigned MASTERS = 4,
  parameter int unsigned MIDX    = $clog2(MASTERS)
) (
  input  logic               clock,
  input  logic               Hreset,
  input  logic [MASTERS-1:0] Hbusreq,
  input  logic [MASTERS-1:0] Hlock,
  input  logic [1:0]         Htrans,
  input  logic [2:0]         Hburst,
  input  logic               Hreadyout,
  output logic [MASTERS-1:0] Hgrant,
  output logic [MIDX-1:0]    Hmaster,
  output logic [MIDX-1:0]    Hmaster_d,
  output logic               Hmastlock
);

  typedef enum logic [1:0] {StIdle, StOwn, StBurst} state_e;

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;
  localparam logic [2:0] BurstSingle = 3'b000;
  localparam logic [2:0] BurstIncr   = 3'b001;
  localparam logic [MASTERS-1:0] GrantPark = MASTERS'(1);

  function automatic logic [4:0] beats_m1(input logic [2:0] burst);
    case (burst)
      3'b010, 3'b011: beats_m1 = 5'd3;
      3'b100, 3'b101: beats_m1 = 5'd7;
      3'b110, 3'b111: beats_m1 = 5'd15;
      default:        beats_m1 = 5'd0;  // SINGLE, and INCR where the counter is unused
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               incr_q, incr_d;
  logic [MIDX-1:0]    owner_q, owner_d;
  logic [MIDX-1:0]    last_q, last_d;
  logic [MIDX-1:0]    downer_q;
  logic [MASTERS-1:0] grant_q, grant_d;
  logic               lock_q, lock_d;

  logic nonseq_acc, seq_acc, incr_beat, rearb, keep;
  logic found;
  logic [MIDX-1:0] pick;
  int unsigned cand;

  assign nonseq_acc = Hreadyout && (Htrans == TransNonseq);
  assign seq_acc    = Hreadyout && (Htrans == TransSeq);
  // INCR status comes from Hburst on the opening beat, from the stored flag afterwards
  assign incr_beat  = nonseq_acc ? (Hburst == BurstIncr) : (seq_acc && incr_q);
  assign rearb      = Hreadyout && ((Htrans == TransIdle) ||
                                    (nonseq_acc && (Hburst == BurstSingle)) ||
                                    (seq_acc && (cnt_q == 5'd1)) ||
                                    (incr_beat && !Hbusreq[owner_q]));

`ifdef ARB_LOCK_EN
  assign keep = (state_q != StIdle) && Hlock[owner_q];
`else
  logic unused_lock;
  assign unused_lock = ^Hlock;
  assign keep        = 1'b0;
`endif

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int unsigned k = 1; k <= MASTERS; k++) begin
      cand = (32'(last_q) + k) % MASTERS;
      if (!found && Hbusreq[cand[MIDX-1:0]]) begin
        found = 1'b1;
        pick  = cand[MIDX-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    incr_d  = incr_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    lock_d  = lock_q;
    if (nonseq_acc) begin
      cnt_d  = beats_m1(Hburst);
      incr_d = (Hburst == BurstIncr);
    end else if (seq_acc && (cnt_q != 5'd0)) begin
      cnt_d = cnt_q - 5'd1;
    end
    if (rearb) begin
      if (keep) begin
        lock_d  = 1'b1;
        state_d = StOwn;
      end else begin
        lock_d = 1'b0;
        if (found) begin
          owner_d = pick;
          last_d  = pick;
          grant_d = GrantPark << pick;
          state_d = StOwn;
        end else begin
          owner_d = '0;
          grant_d = GrantPark;
          state_d = StIdle;
        end
      end
    end else if (nonseq_acc && (state_q != StIdle)) begin
      state_d = StBurst;
    end
  end

  always_ff @(posedge clock) begin
    if (Hreset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      incr_q   <= 1'b0;
      owner_q  <= '0;
      last_q   <= MIDX'(MASTERS - 1);
      downer_q <= '0;
      grant_q  <= GrantPark;
      lock_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      incr_q  <= incr_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      lock_q  <= lock_d;
      if (Hreadyout) downer_q <= owner_q;
    end
  end

  assign Hgrant    = grant_q;
  assign Hmaster   = owner_q;
  assign Hmaster_d = downer_q;
  assign Hmastlock = lock_q;

endmodule

// File: tb/tb_bridge_ahb_arbiter.sv
// Scoreboard bench for bridge_ahb_arbiter: directed bus scenarios plus random traffic
// checked against a transaction-level ownership model.
module tb_bridge_ahb_arbiter;

  localparam int unsigned M  = 4;
  localparam int unsigned MI = 2;
`ifdef ARB_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          Hreset = 1'b1;
  logic [M-1:0]  Hbusreq = '0;
  logic [M-1:0]  Hlock = '0;
  logic [1:0]    Htrans = 2'b00;
  logic [2:0]    Hburst = 3'b000;
  logic          Hreadyout = 1'b1;
  logic [M-1:0]  Hgrant;
  logic [MI-1:0] Hmaster;
  logic [MI-1:0] Hmaster_d;
  logic          Hmastlock;

  bridge_ahb_arbiter #(.MASTERS(M), .MIDX(MI)) dut (
    .clock    (clock),
    .Hreset   (Hreset),
    .Hbusreq  (Hbusreq),
    .Hlock    (Hlock),
    .Htrans   (Htrans),
    .Hburst   (Hburst),
    .Hreadyout(Hreadyout),
    .Hgrant   (Hgrant),
    .Hmaster  (Hmaster),
    .Hmaster_d(Hmaster_d),
    .Hmastlock(Hmastlock)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [M-1:0]  grant;
    logic [MI-1:0] mst;
    logic [MI-1:0] mst_d;
    logic          lock;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   compared = 0;
  int   mismatched = 0;

  // Reference model: who owns the bus, how many beats remain, who owned the last address phase.
  bit m_owned;
  int m_owner, m_last, m_left, m_dph;
  bit m_unb, m_lock;

  function automatic int burst_beats(input logic [2:0] b);
    case (b)
      3'b000:         return 1;
      3'b001:         return 0;
      3'b010, 3'b011: return 4;
      3'b100, 3'b101: return 8;
      default:        return 16;
    endcase
  endfunction

  function automatic void model_step(input logic rst, input logic [M-1:0] bq, input logic [M-1:0] lk,
                                     input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    bit done;
    if (rst) begin
      m_owned = 0; m_owner = 0; m_last = M - 1; m_left = 0; m_unb = 0; m_lock = 0; m_dph = 0;
      return;
    end
    if (!rdy) return;
    done = (tr == 2'b00) || (tr == 2'b10 && bu == 3'b000) || (tr == 2'b11 && m_left == 1) ||
           (tr[1] && ((tr == 2'b10) ? (bu == 3'b001) : m_unb) && !bq[m_owner]);
    if (tr == 2'b10) begin
      m_unb  = (bu == 3'b001);
      m_left = m_unb ? 0 : burst_beats(bu) - 1;
    end else if (tr == 2'b11 && m_left > 0) begin
      m_left = m_left - 1;
    end
    m_dph = m_owner;
    if (done) begin
      if (LockEn && m_owned && lk[m_owner]) begin
        m_lock = 1;
      end else begin
        m_lock  = 0;
        m_owned = 0;
        m_owner = 0;
        for (int k = 1; k <= M; k++) begin
          if (!m_owned && bq[(m_last + k) % M]) begin
            m_owned = 1;
            m_owner = (m_last + k) % M;
            m_last  = m_owner;
          end
        end
      end
    end
  endfunction

  task automatic cyc(input logic rst, input logic [M-1:0] bq, input logic [M-1:0] lk,
                     input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    exp_t e;
    @(negedge clock);
    #1;
    Hreset = rst; Hbusreq = bq; Hlock = lk; Htrans = tr; Hburst = bu; Hreadyout = rdy;
    model_step(rst, bq, lk, tr, bu, rdy);
    e.grant = M'(1) << m_owner;
    e.mst   = MI'(m_owner);
    e.mst_d = MI'(m_dph);
    e.lock  = m_lock;
    exp_q.push_back(e);
  endtask

  // Monitor: each negedge checks the outputs produced by the preceding rising edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      compared++;
      if ({Hgrant, Hmaster, Hmaster_d, Hmastlock} !== mon_e) begin
        mismatched++;
        $display("FAIL outputs t=%0t: got grant=%b mst=%0d mst_d=%0d lock=%b, want grant=%b mst=%0d mst_d=%0d lock=%b",
                 $time, Hgrant, Hmaster, Hmaster_d, Hmastlock,
                 mon_e.grant, mon_e.mst, mon_e.mst_d, mon_e.lock);
      end
    end
  end

  initial begin
    // Reset then an idle bus
    cyc(1, 4'b0000, 4'b0000, 2'b00, 3'b000, 1);
    for (int i = 0; i < 5; i++) cyc(0, 4'b0000, 4'b0000, 2'b00, 3'b000, 1);

    // Everyone requesting, one SINGLE per owner
    cyc(0, 4'b1111, 4'b0000, 2'b00, 3'b000, 1);
    for (int i = 0; i < 5; i++) cyc(0, 4'b1111, 4'b0000, 2'b10, 3'b000, 1);

    // Master 1 INCR4 with wait states on beat 3, master 2 waiting
    cyc(1, 4'b0000, 4'b0000, 2'b00, 3'b000, 1);
    cyc(0, 4'b0010, 4'b0000, 2'b00, 3'b000, 1);
    cyc(0, 4'b0110, 4'b0000, 2'b10, 3'b011, 1);
    cyc(0, 4'b0110, 4'b0000, 2'b11, 3'b011, 1);
    cyc(0, 4'b0110, 4'b0000, 2'b11, 3'b011, 0);
    cyc(0, 4'b0110, 4'b0000, 2'b11, 3'b011, 0);
    cyc(0, 4'b0110, 4'b0000, 2'b11, 3'b011, 1);
    cyc(0, 4'b0110, 4'b0000, 2'b11, 3'b011, 1);
    cyc(0, 4'b0100, 4'b0000, 2'b00, 3'b000, 1);

    // Master 0 INCR8 terminated early by IDLE
    cyc(1, 4'b0000, 4'b0000, 2'b00, 3'b000, 1);
    cyc(0, 4'b0011, 4'b0000, 2'b00, 3'b000, 1);
    cyc(0, 4'b0011, 4'b0000, 2'b10, 3'b101, 1);
    cyc(0, 4'b0011, 4'b0000, 2'b11, 3'b101, 1);
    cyc(0, 4'b0011, 4'b0000, 2'b11, 3'b101, 1);
    cyc(0, 4'b0011, 4'b0000, 2'b00, 3'b101, 1);
    cyc(0, 4'b0010, 4'b0000, 2'b10, 3'b000, 1);

    // Master 3 locked across two INCR4 bursts, master 0 waiting
    cyc(1, 4'b0000, 4'b0000, 2'b00, 3'b000, 1);
    cyc(0, 4'b1000, 4'b1000, 2'b00, 3'b000, 1);
    for (int b = 0; b < 2; b++) begin
      cyc(0, 4'b1001, 4'b1000, 2'b10, 3'b011, 1);
      for (int s = 0; s < 3; s++)
        cyc(0, 4'b1001, (b == 1 && s == 2) ? 4'b0000 : 4'b1000, 2'b11, 3'b011, 1);
    end
    cyc(0, 4'b0001, 4'b0000, 2'b00, 3'b000, 1);

    // Reset during beat 2 of a WRAP8 from master 2
    cyc(1, 4'b0000, 4'b0000, 2'b00, 3'b000, 1);
    cyc(0, 4'b0100, 4'b0000, 2'b00, 3'b000, 1);
    cyc(0, 4'b0100, 4'b0000, 2'b10, 3'b100, 1);
    cyc(1, 4'b0100, 4'b0000, 2'b11, 3'b100, 1);
    cyc(0, 4'b1111, 4'b0000, 2'b00, 3'b000, 1);
    cyc(0, 4'b1111, 4'b0000, 2'b10, 3'b000, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
          M'($urandom),
          ($urandom_range(0, 2) == 0) ? M'($urandom) : '0,
          2'($urandom),
          3'($urandom),
          ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0);
    end

    @(negedge clock);
    #2;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
